// File: rtl/seq_det_event_logger_if.sv
// Event stream between the logger and its consumer: valid/ready handshake
// carrying the bit index of each detected match.
interface seq_det_event_logger_if #(
    parameter int IDX_W = 16
) ();

    logic             evt_valid;
    logic             evt_ready;
    logic [IDX_W-1:0] evt_idx;

    // Logger side: presents events, observes the consumer's ready.
    modport master (
        output evt_valid,
        output evt_idx,
        input  evt_ready
    );

    // Consumer side: observes events, drives ready.
    modport slave (
        input  evt_valid,
        input  evt_idx,
        output evt_ready
    );

endinterface

// File: rtl/seq_det_event_logger.sv
// seq_det_event_logger: runs beside the 1011 sequence detector, numbers every
// qualified serial bit, queues the index of each match-completing bit in a
// small first-word fall-through FIFO, keeps a saturating match total and
// flags any event lost to a full FIFO.
module seq_det_event_logger #(
    parameter int IDX_W = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bit_vld,
    input  logic                     match,
    input  logic                     clr,
    seq_det_event_logger_if.master   evt,
    output logic [CNT_W-1:0]         match_cnt,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [IDX_W-1:0] bit_idx;
    logic [IDX_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    level;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             push_ok;

    // The extra pointer bit separates full (level == DEPTH) from empty.
    assign level   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (level == PW'(DEPTH));

    // match is only meaningful alongside a qualified bit.
    assign push    = bit_vld & match;
    // Pop depends on the registered empty flag, so a push into an empty FIFO
    // is never bypassed to the output in the same cycle.
    assign pop     = ~empty & evt.evt_ready;
    // When full, a push is accepted only if the head leaves on the same edge.
    assign push_ok = push & (~full | pop);

    assign fifo_level    = level;
    assign evt.evt_valid = ~empty;
    assign evt.evt_idx   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Bit index, FIFO pointers, saturating match count and sticky overflow;
    // clr wins over every other update in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every update
        // in this block sees the pre-edge values of the others.
        if (!rst) begin
            bit_idx   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            match_cnt <= '0;
            overflow  <= 1'b0;
        end else if (clr) begin
            bit_idx   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            match_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            if (bit_vld) begin
                bit_idx <= bit_idx + IDX_W'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && (match_cnt != CNT_MAX)) begin
                match_cnt <= match_cnt + CNT_W'(1);
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // Event storage: captures the pre-increment bit index on an accepted push.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; an entry is only ever read after it has
        // been written, and evt_idx is forced to 0 while the FIFO is empty.
        if (push_ok && !clr) begin
            mem[wr_ptr[AW-1:0]] <= bit_idx;
        end
    end

endmodule

// File: tb/tb_seq_det_event_logger.sv
// Directed bench for seq_det_event_logger: a default-parameter instance for
// ordering, full/empty, clr and reset behaviour, and a narrow instance
// (IDX_W=4, CNT_W=2) for index wrap and counter saturation.
module tb_seq_det_event_logger;

    localparam int IDX_W  = 16;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 8;
    localparam int SIDX_W = 4;
    localparam int SCNT_W = 2;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;

    logic              a_bit_vld;
    logic              a_match;
    logic              a_clr;
    logic [CNT_W-1:0]  a_match_cnt;
    logic              a_overflow;
    logic [LW-1:0]     a_level;

    logic              b_bit_vld;
    logic              b_match;
    logic              b_clr;
    logic [SCNT_W-1:0] b_match_cnt;
    logic              b_overflow;
    logic [LW-1:0]     b_level;

    int vectors     = 0;
    int miscompares = 0;

    seq_det_event_logger_if #(.IDX_W(IDX_W))  a_evt ();
    seq_det_event_logger_if #(.IDX_W(SIDX_W)) b_evt ();

    seq_det_event_logger #(.IDX_W(IDX_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .bit_vld    (a_bit_vld),
        .match      (a_match),
        .clr        (a_clr),
        .evt        (a_evt),
        .match_cnt  (a_match_cnt),
        .overflow   (a_overflow),
        .fifo_level (a_level)
    );

    seq_det_event_logger #(.IDX_W(SIDX_W), .DEPTH(DEPTH), .CNT_W(SCNT_W)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .bit_vld    (b_bit_vld),
        .match      (b_match),
        .clr        (b_clr),
        .evt        (b_evt),
        .match_cnt  (b_match_cnt),
        .overflow   (b_overflow),
        .fifo_level (b_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input int valid, input int idx,
                           input int level, input int cnt, input int ovf);
        check({tag, ".valid"},    32'(a_evt.evt_valid), 32'(valid));
        check({tag, ".idx"},      32'(a_evt.evt_idx),   32'(idx));
        check({tag, ".level"},    32'(a_level),         32'(level));
        check({tag, ".cnt"},      32'(a_match_cnt),     32'(cnt));
        check({tag, ".overflow"}, 32'(a_overflow),      32'(ovf));
    endtask

    task automatic check_b(input string tag, input int valid, input int idx,
                           input int level, input int cnt, input int ovf);
        check({tag, ".valid"},    32'(b_evt.evt_valid), 32'(valid));
        check({tag, ".idx"},      32'(b_evt.evt_idx),   32'(idx));
        check({tag, ".level"},    32'(b_level),         32'(level));
        check({tag, ".cnt"},      32'(b_match_cnt),     32'(cnt));
        check({tag, ".overflow"}, 32'(b_overflow),      32'(ovf));
    endtask

    // Drive one cycle of inputs on instance A, then sample 1 ns after the edge.
    task automatic step_a(input logic bv, input logic m, input logic rdy, input logic c);
        a_bit_vld       = bv;
        a_match         = m;
        a_evt.evt_ready = rdy;
        a_clr           = c;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic bv, input logic m, input logic rdy, input logic c);
        b_bit_vld       = bv;
        b_match         = m;
        b_evt.evt_ready = rdy;
        b_clr           = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b0;
        a_bit_vld       = 1'b0;
        a_match         = 1'b0;
        a_clr           = 1'b0;
        a_evt.evt_ready = 1'b0;
        b_bit_vld       = 1'b0;
        b_match         = 1'b0;
        b_clr           = 1'b0;
        b_evt.evt_ready = 1'b0;

        // Reset state, observed while rst is still asserted.
        #2;
        check_a("reset_a", 0, 0, 0, 0, 0);
        check_b("reset_b", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        // Narrow instance: 17 qualified bits, match on the 17th -> index wraps to 0.
        for (int i = 0; i < 17; i++) begin
            step_b(1'b1, (i == 16), 1'b1, 1'b0);
        end
        check_b("wrap", 1, 0, 1, 1, 0);
        // Four more matches (indices 1..4); count saturates at 3.
        for (int k = 0; k < 4; k++) begin
            step_b(1'b1, 1'b1, 1'b1, 1'b0);
            check_b($sformatf("sat%0d", k), 1, k + 1, 1, (k + 2 > 3) ? 3 : k + 2, 0);
        end
        step_b(1'b0, 1'b0, 1'b1, 1'b0);
        check_b("sat_drained", 0, 0, 0, 3, 0);
        step_b(1'b0, 1'b0, 1'b0, 1'b0);

        // Serial 1,0,1,1,0,1,1: matches complete at indices 3 and 6.
        step_a(1'b1, 1'b0, 1'b1, 1'b0);
        step_a(1'b1, 1'b0, 1'b1, 1'b0);
        step_a(1'b1, 1'b0, 1'b1, 1'b0);
        check("seq.pre_push_valid", 32'(a_evt.evt_valid), 32'd0);
        step_a(1'b1, 1'b1, 1'b1, 1'b0);
        check_a("seq.ev3", 1, 3, 1, 1, 0);
        step_a(1'b1, 1'b0, 1'b1, 1'b0);
        check_a("seq.pop3", 0, 0, 0, 1, 0);
        step_a(1'b1, 1'b0, 1'b1, 1'b0);
        step_a(1'b1, 1'b1, 1'b1, 1'b0);
        check_a("seq.ev6", 1, 6, 1, 2, 0);
        step_a(1'b0, 1'b0, 1'b1, 1'b0);
        check_a("seq.drained", 0, 0, 0, 2, 0);

        // Overflow: clr, then matches at 2,4,6,8,10 with the consumer stalled.
        step_a(1'b0, 1'b0, 1'b0, 1'b1);
        check_a("ovf.clr", 0, 0, 0, 0, 0);
        for (int i = 0; i <= 10; i++) begin
            step_a(1'b1, (i >= 2) && (i % 2 == 0), 1'b0, 1'b0);
            if (i == 8) begin
                check_a("ovf.full", 1, 2, 4, 4, 0);
            end
        end
        check_a("ovf.dropped", 1, 2, 4, 5, 1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ovf.head%0d", k), 32'(a_evt.evt_idx), 32'(2 + 2 * k));
            step_a(1'b0, 1'b0, 1'b1, 1'b0);
        end
        check_a("ovf.empty", 0, 0, 0, 5, 1);

        // Full FIFO with simultaneous push (index 20) and pop: nothing dropped.
        step_a(1'b0, 1'b0, 1'b0, 1'b1);
        check_a("pp.clr", 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step_a(1'b1, (i >= 16), 1'b0, 1'b0);
        end
        check_a("pp.full", 1, 16, 4, 4, 0);
        step_a(1'b1, 1'b1, 1'b1, 1'b0);
        check_a("pp.pushpop", 1, 17, 4, 5, 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("pp.head%0d", k), 32'(a_evt.evt_idx), 32'(17 + k));
            step_a(1'b0, 1'b0, 1'b1, 1'b0);
        end
        check_a("pp.empty", 0, 0, 0, 5, 0);

        // match without bit_vld is ignored; the next qualified bit is index 21.
        for (int k = 0; k < 3; k++) begin
            step_a(1'b0, 1'b1, 1'b0, 1'b0);
            check_a($sformatf("ign%0d", k), 0, 0, 0, 5, 0);
        end
        step_a(1'b1, 1'b1, 1'b0, 1'b0);
        check_a("ign.next", 1, 21, 1, 6, 0);
        step_a(1'b1, 1'b1, 1'b0, 1'b0);
        check_a("rst.queued", 1, 21, 2, 7, 0);

        // Asynchronous reset pulse between edges clears everything at once.
        a_bit_vld = 1'b0;
        a_match   = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        check_a("rst.async", 0, 0, 0, 0, 0);
        #1;
        rst = 1'b1;
        step_a(1'b1, 1'b1, 1'b0, 1'b0);
        check_a("rst.next", 1, 0, 1, 1, 0);

        // clr on an edge carrying a match: all cleared, that match discarded.
        step_a(1'b1, 1'b1, 1'b0, 1'b0);
        check_a("clr.queued", 1, 0, 2, 2, 0);
        step_a(1'b1, 1'b1, 1'b0, 1'b1);
        check_a("clr.cleared", 0, 0, 0, 0, 0);
        step_a(1'b1, 1'b1, 1'b0, 1'b0);
        check_a("clr.next", 1, 0, 1, 1, 0);
        step_a(1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
